// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci term sequencer.
package fib_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_COUNT_W = 8;

  // Datapath seed: b is the term on display, a is the next one.
  localparam int A_INIT = 1;
  localparam int B_INIT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fib_sequencer_if.sv
// Start request and term stream handshakes of the Fibonacci sequencer.
interface fib_sequencer_if
  import fib_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int COUNT_W = DEF_COUNT_W
);

  logic               start_valid;
  logic               start_ready;
  logic [COUNT_W-1:0] start_count;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;

  // The sequencer is the slave of the start request and the source of terms.
  modport slave (
    input  start_valid, start_count, out_ready,
    output start_ready, out_valid, out_data, out_last
  );

  modport master (
    output start_valid, start_count, out_ready,
    input  start_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/fib_datapath.sv
// Add/shift register pair producing consecutive Fibonacci terms with sticky carry.
module fib_datapath
  import fib_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             a_ovf
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  // NOTE: state registers use non-blocking assignments so b picks up the old a.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a     <= WIDTH'(A_INIT);
      b     <= WIDTH'(B_INIT);
      a_ovf <= 1'b0;
    end else if (load) begin
      a     <= WIDTH'(A_INIT);
      b     <= WIDTH'(B_INIT);
      a_ovf <= 1'b0;
    end else if (step) begin
      a     <= sum[WIDTH-1:0];
      b     <= a;
      a_ovf <= a_ovf | sum[WIDTH];
    end
  end

endmodule

// File: rtl/fib_sequencer.sv
// Streams a requested number of Fibonacci terms with backpressure, stopping on overflow or abort.
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic          clock,
  input  logic          reset,
  fib_sequencer_if.slave bus,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  state_t             state;
  logic [COUNT_W-1:0] remaining;
  logic [WIDTH-1:0]   b;
  logic               a_ovf;
  logic               load;
  logic               fire;
  logic               last;

  assign load = (state == IDLE) && bus.start_valid;
  assign fire = (state == EMIT) && bus.out_ready;
  // A pending carry means the next term would be wrong, so the current one is final.
  assign last = (remaining == COUNT_W'(1)) || a_ovf;

  fib_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .step  (fire),
    .a     (),
    .b     (b),
    .a_ovf (a_ovf)
  );

  // NOTE: reset is asynchronous so out_valid drops the instant reset rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            remaining <= bus.start_count;
            overflow  <= 1'b0;
            state     <= (bus.start_count == '0) ? DONE : EMIT;
          end
        end
        EMIT: begin
          if (fire) begin
            remaining <= remaining - COUNT_W'(1);
            if (last) begin
              state <= DONE;
              if (a_ovf && (remaining > COUNT_W'(1))) overflow <= 1'b1;
            end
          end
          if (abort) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = (state == IDLE);
  assign bus.out_valid   = (state == EMIT);
  assign bus.out_data    = b;
  assign bus.out_last    = (state == EMIT) && last;
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);

endmodule

// File: tb/tb_fib_sequencer.sv
// Randomized bench for fib_sequencer against a plain-arithmetic Fibonacci model.
module tb_fib_sequencer;
  import fib_pkg::*;

  localparam int WIDTH   = DEF_WIDTH;
  localparam int COUNT_W = DEF_COUNT_W;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic abort = 1'b0;
  logic busy, done, overflow;

  int errors = 0;
  int checks = 0;

  int exp_q[$];

  fib_sequencer_if #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) bus ();

  fib_sequencer #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus.slave),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Terms F(0)..F(count-1), cut after the first term whose successor no longer fits.
  function automatic void build_model(input int count);
    longint x, y, t;
    exp_q.delete();
    x = 0;
    y = 1;
    for (int k = 0; k < count; k++) begin
      exp_q.push_back(int'(x));
      if (y >= (longint'(1) << WIDTH)) break;
      t = x + y;
      x = y;
      y = t;
    end
  endfunction

  // Starts at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run(input int count, input int mode, input int abort_at, input bit noise);
    int idx = 0;
    int cyc = 0;
    int exp_cons;
    bit done_seen = 0;
    bit aborted = 0;
    bit pstall = 0;
    bit plast = 0;
    logic [WIDTH-1:0] pdata = '0;
    bit r, ab;

    build_model(count);
    exp_cons = exp_q.size();
    check("idle_ready", bus.start_ready, 1);
    bus.start_valid = 1'b1;
    bus.start_count = COUNT_W'(count);
    @(negedge clock);
    bus.start_valid = 1'b0;
    check("ovf_cleared_on_start", overflow, 0);
    check("busy_after_start", busy, 1);

    if (count == 0) begin
      check("zero_no_valid", bus.out_valid, 0);
      check("zero_done", done, 1);
      @(negedge clock);
      check("zero_done_drop", done, 0);
      check("zero_ready_back", bus.start_ready, 1);
      return;
    end

    while (cyc < 500) begin
      if (done) begin
        done_seen = 1;
        break;
      end
      check("valid_held", bus.out_valid, 1);
      if (pstall) begin
        check("stall_data", bus.out_data, pdata);
        check("stall_last", bus.out_last, plast);
      end
      r  = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      ab = (abort_at >= 0) && (idx == abort_at) && !aborted;
      bus.out_ready = r;
      abort = ab;
      if (noise) begin
        bus.start_valid = 1'($urandom_range(0, 1));
        bus.start_count = COUNT_W'($urandom_range(0, 3));
      end
      if (r) begin
        if (idx < exp_q.size()) begin
          check("term", bus.out_data, exp_q[idx]);
          check("last_flag", bus.out_last, (idx == exp_q.size() - 1));
        end else begin
          check("extra_term", idx, exp_q.size());
        end
        idx++;
      end
      if (ab) begin
        aborted  = 1;
        exp_cons = idx;
      end
      pstall = !r;
      pdata  = bus.out_data;
      plast  = bus.out_last;
      @(negedge clock);
      cyc++;
    end

    bus.start_valid = 1'b0;
    bus.out_ready   = 1'b0;
    abort           = 1'b0;
    check("done_seen", done_seen, 1);
    check("term_count", idx, exp_cons);
    if (mode == 0 && !aborted) check("one_per_cycle", cyc, exp_q.size());
    check("done_no_valid", bus.out_valid, 0);
    check("overflow_flag", overflow, (exp_cons == exp_q.size()) && (exp_q.size() < count));

    // Requests and aborts landing in the DONE cycle must be ignored.
    bus.start_valid = noise;
    abort = noise;
    @(negedge clock);
    bus.start_valid = 1'b0;
    abort = 1'b0;
    check("done_one_cycle", done, 0);
    check("ready_back", bus.start_ready, 1);
    check("busy_off", busy, 0);
    check("no_restart", bus.out_valid, 0);
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.start_count = '0;
    bus.out_ready   = 1'b0;

    #1 reset = 1'b1;
    #1;
    check("rst_start_ready", bus.start_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    run(5, 0, -1, 0);
    run(20, 0, -1, 0);
    repeat (3) @(negedge clock);
    check("overflow_sticky", overflow, 1);

    // Reset while idle clears the sticky flag.
    #2 reset = 1'b1;
    #1 check("rst_clears_ovf", overflow, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    run(20, 0, -1, 0);
    run(14, 0, -1, 0);
    run(5, 0, -1, 0);
    run(6, 1, -1, 0);
    run(0, 0, -1, 0);
    run(10, 0, 2, 1);

    // Reset between edges in the middle of a run.
    bus.start_valid = 1'b1;
    bus.start_count = COUNT_W'(10);
    @(negedge clock);
    bus.start_valid = 1'b0;
    bus.out_ready   = 1'b1;
    repeat (2) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrun_valid_drop", bus.out_valid, 0);
    check("midrun_busy_drop", busy, 0);
    check("midrun_no_done", done, 0);
    check("midrun_ready", bus.start_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check("post_rst_no_done", done, 0);
    end
    run(3, 0, -1, 0);

    for (int i = 0; i < 12; i++) begin
      run($urandom_range(0, 25), $urandom_range(0, 2),
          ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1,
          1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
